// File: rtl/pit_top_level_if.sv
// IPIF-style slave bus bundle for the PIT: chip-enabled reads and writes
// with byte lanes and combinational acknowledges.
interface pit_top_level_if;
    logic [31:0] Bus2IP_Data;
    logic [3:0]  Bus2IP_BE;
    logic [1:0]  Bus2IP_RdCE;
    logic [1:0]  Bus2IP_WrCE;
    logic [31:0] IP2Bus_Data;
    logic        IP2Bus_RdAck;
    logic        IP2Bus_WrAck;
    logic        IP2Bus_Error;

    modport master (
        output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
        input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );

    modport slave (
        input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
        output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );
endinterface

// File: rtl/pit_top_level.sv
// Programmable interval timer: control + period registers behind an
// IPIF-style slave, a 32-bit down-counter with optional auto-reload and a
// registered one-cycle interrupt pulse at expiry.
module pit_top_level (
    input  logic                   Bus2IP_Clk,
    input  logic                   Bus2IP_Reset,
    pit_top_level_if.slave         bus,
    output logic                   IP_Interupt,
    output logic [31:0]            counter,
    output logic [31:0]            slv_reg0,
    output logic [31:0]            slv_reg1
);

    logic [31:0] reg0_wr;
    logic [31:0] reg1_wr;
    logic        ctl_en;
    logic        ctl_ie;
    logic        ctl_rl;

    // Counter logic acts on the control value held before the edge.
    assign ctl_en = slv_reg0[0];
    assign ctl_ie = slv_reg0[1];
    assign ctl_rl = slv_reg0[2];

    // Post-write register values: byte-lane merge of bus data under BE.
    always_comb begin
        reg0_wr = slv_reg0;
        reg1_wr = slv_reg1;
        for (int i = 0; i < 4; i++) begin
            if (bus.Bus2IP_WrCE[1] && bus.Bus2IP_BE[i])
                reg0_wr[8*i +: 8] = bus.Bus2IP_Data[8*i +: 8];
            if (bus.Bus2IP_WrCE[0] && bus.Bus2IP_BE[i])
                reg1_wr[8*i +: 8] = bus.Bus2IP_Data[8*i +: 8];
        end
    end

    // Read mux; only a single asserted chip enable selects a register.
    always_comb begin
        case (bus.Bus2IP_RdCE)
            2'b10:   bus.IP2Bus_Data = slv_reg0;
            2'b01:   bus.IP2Bus_Data = slv_reg1;
            default: bus.IP2Bus_Data = 32'd0;
        endcase
    end

    assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
    assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
    assign bus.IP2Bus_Error = 1'b0;

    // Registers, counter and interrupt; a period write beats expiry, and an
    // idle zero counter with reload enabled restarts without an interrupt.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            slv_reg0    <= 32'd0;
            slv_reg1    <= 32'd0;
            counter     <= 32'd0;
            IP_Interupt <= 1'b0;
        end else begin
            slv_reg0    <= reg0_wr;
            slv_reg1    <= reg1_wr;
            IP_Interupt <= 1'b0;
            if (bus.Bus2IP_WrCE[0]) begin
                counter <= reg1_wr;
            end else if (ctl_en) begin
                if (counter > 32'd1) begin
                    counter <= counter - 32'd1;
                end else if (counter == 32'd1) begin
                    counter     <= ctl_rl ? slv_reg1 : 32'd0;
                    IP_Interupt <= ctl_ie;
                end else if (ctl_rl) begin
                    counter <= slv_reg1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pit_top_level.sv
// Bench for pit_top_level: directed test-plan sequence followed by random
// bus traffic, checked cycle by cycle against a behavioural timer model via
// an expectation queue drained by an independent monitor.
module tb_pit_top_level;

    typedef struct {
        logic [31:0] rd_data;
        logic        rd_ack;
        logic        wr_ack;
        logic [31:0] reg0;
        logic [31:0] reg1;
        logic [31:0] cnt;
        logic        irq;
    } exp_t;

    logic Bus2IP_Clk = 1'b0;
    logic Bus2IP_Reset;
    logic        IP_Interupt;
    logic [31:0] counter, slv_reg0, slv_reg1;

    pit_top_level_if bus ();

    pit_top_level dut (
        .Bus2IP_Clk   (Bus2IP_Clk),
        .Bus2IP_Reset (Bus2IP_Reset),
        .bus          (bus),
        .IP_Interupt  (IP_Interupt),
        .counter      (counter),
        .slv_reg0     (slv_reg0),
        .slv_reg1     (slv_reg1)
    );

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    exp_t   exp_q[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    bit     done   = 0;

    // Reference model state: registers, time remaining, pending interrupt.
    longint m_r0 = 0, m_r1 = 0, m_cnt = 0;
    bit     m_irq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint lane_merge(longint old, logic [31:0] d, logic [3:0] be);
        longint mask = 0;
        for (int i = 0; i < 4; i++)
            if (be[i]) mask |= (longint'(8'hFF) << (8 * i));
        return (old & ~mask) | (longint'(d) & mask);
    endfunction

    // One bus cycle: drive inputs, record what the DUT should show now and
    // after the coming edge, then advance the model.
    task automatic cyc(input bit rst, input logic [1:0] wr, input logic [1:0] rd,
                       input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        longint n0, n1;
        @(posedge Bus2IP_Clk);
        #1;
        Bus2IP_Reset    = rst;
        bus.Bus2IP_WrCE = wr;
        bus.Bus2IP_RdCE = rd;
        bus.Bus2IP_BE   = be;
        bus.Bus2IP_Data = d;
        e.rd_data = (rd == 2'b10) ? 32'(m_r0) : (rd == 2'b01) ? 32'(m_r1) : 32'd0;
        e.rd_ack  = (rd != 0);
        e.wr_ack  = (wr != 0);
        if (rst) begin
            m_r0 = 0; m_r1 = 0; m_cnt = 0; m_irq = 0;
        end else begin
            n0 = wr[1] ? lane_merge(m_r0, d, be) : m_r0;
            n1 = wr[0] ? lane_merge(m_r1, d, be) : m_r1;
            m_irq = 0;
            if (wr[0]) m_cnt = n1;
            else if (m_r0[0]) begin
                if (m_cnt == 1) begin
                    m_irq = m_r0[1];
                    m_cnt = m_r0[2] ? m_r1 : 0;
                end else if (m_cnt == 0) begin
                    if (m_r0[2]) m_cnt = m_r1;
                end else m_cnt = m_cnt - 1;
            end
            m_r0 = n0; m_r1 = n1;
        end
        e.reg0 = 32'(m_r0); e.reg1 = 32'(m_r1); e.cnt = 32'(m_cnt); e.irq = m_irq;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [1:0] rd);
        for (int i = 0; i < n; i++) cyc(0, 2'b00, rd, 4'h0, 32'd0);
    endtask

    // Monitor: combinational outputs mid-cycle, registered state after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Bus2IP_Clk);
            chk("bus_error", {31'd0, bus.IP2Bus_Error}, 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_ack", {31'd0, bus.IP2Bus_RdAck}, {31'd0, e.rd_ack});
                chk("wr_ack", {31'd0, bus.IP2Bus_WrAck}, {31'd0, e.wr_ack});
                if (e.rd_ack) chk("rd_data", bus.IP2Bus_Data, e.rd_data);
                @(posedge Bus2IP_Clk);
                #2;
                chk("slv_reg0", slv_reg0, e.reg0);
                chk("slv_reg1", slv_reg1, e.reg1);
                chk("counter", counter, e.cnt);
                chk("interrupt", {31'd0, IP_Interupt}, {31'd0, e.irq});
            end
        end
    end

    // Stimulus: test-plan sequence, then randomized traffic.
    initial begin : stim
        int r;
        Bus2IP_Reset = 1'b1;
        bus.Bus2IP_WrCE = 0; bus.Bus2IP_RdCE = 0; bus.Bus2IP_BE = 0; bus.Bus2IP_Data = 0;
        cyc(1, 2'b00, 2'b00, 4'h0, 32'd0);
        cyc(1, 2'b10, 2'b00, 4'hF, 32'hFFFF_FFFF);  // reset beats a write
        cyc(0, 2'b01, 2'b00, 4'hF, 32'd30);
        cyc(0, 2'b10, 2'b00, 4'hF, 32'h1);
        idle(34, 2'b01);
        cyc(0, 2'b10, 2'b10, 4'hF, 32'h5);
        idle(65, 2'b00);
        cyc(0, 2'b10, 2'b00, 4'hF, 32'h7);
        idle(65, 2'b10);
        cyc(0, 2'b10, 2'b00, 4'hF, 32'h3);
        idle(35, 2'b00);
        cyc(0, 2'b01, 2'b00, 4'b0011, 32'hAABB_CCDD);
        idle(3, 2'b11);
        cyc(0, 2'b01, 2'b00, 4'hF, 32'd1);
        cyc(0, 2'b10, 2'b00, 4'hF, 32'h7);
        idle(8, 2'b01);
        cyc(0, 2'b11, 2'b00, 4'hF, 32'h7);          // both regs written at once
        idle(10, 2'b00);
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)
                cyc(1, 2'b00, 2'($urandom_range(0, 3)), 4'h0, 32'd0);
            else if (r < 7)
                cyc(0, 2'b10, 2'($urandom_range(0, 3)), 4'($urandom),
                    {$urandom_range(0, 255), 3'($urandom)} & 32'h0000_07FF);
            else if (r < 11)
                cyc(0, 2'b01, 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                    32'($urandom_range(0, 7)));
            else if (r < 12)
                cyc(0, 2'b11, 2'($urandom_range(0, 3)), 4'hF, 32'($urandom_range(0, 7)));
            else
                idle(1, 2'($urandom_range(0, 3)));
        end
        idle(2, 2'b00);
        repeat (3) @(posedge Bus2IP_Clk);
        if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
